// File: rtl/tetris_pkg.sv
// Shared types and sizing for the piece queue and its storage.
package tetris_pkg;

  typedef logic [2:0] piece_t;

  localparam int unsigned BAG_SIZE    = 7;
  localparam int unsigned QUEUE_DEPTH = 14;

  // Wide enough for pointers 0..13 and a count of 0..14.
  typedef logic [3:0] qptr_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease
  } req_state_t;

  // Pointer advance modulo QUEUE_DEPTH; inc never exceeds BAG_SIZE.
  function automatic qptr_t ptr_add(qptr_t ptr, qptr_t inc);
    logic [4:0] sum;
    sum = {1'b0, ptr} + {1'b0, inc};
    if (sum >= 5'(QUEUE_DEPTH)) sum = sum - 5'(QUEUE_DEPTH);
    return sum[3:0];
  endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Bag handshake with the randomiser plus the head/preview view for game logic.
interface piece_queue_if
  import tetris_pkg::*;
#(
  parameter int unsigned PREVIEW_N = 3
) ();

  logic                       newbag;
  logic                       ready;
  logic [3*BAG_SIZE-1:0]      pieces;
  logic                       pop;
  piece_t                     piece;
  logic                       piece_valid;
  logic [3*PREVIEW_N-1:0]     preview;
  logic [PREVIEW_N-1:0]       preview_valid;
  logic                       underflow;

  modport master (
    output newbag, piece, piece_valid, preview, preview_valid, underflow,
    input  ready, pieces, pop
  );

  modport slave (
    input  newbag, piece, piece_valid, preview, preview_valid, underflow,
    output ready, pieces, pop
  );

endinterface

// File: rtl/piece_fifo.sv
// Two-bag circular piece store: 7-wide bag write, single pop, head plus preview read.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int unsigned PREVIEW_N = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [3*BAG_SIZE-1:0]  wr_data_i,
  input  logic                   pop_i,
  output qptr_t                  count_o,
  output piece_t                 head_o,
  output logic                   head_valid_o,
  output logic [3*PREVIEW_N-1:0] preview_o,
  output logic [PREVIEW_N-1:0]   preview_valid_o
);

  piece_t mem_q [QUEUE_DEPTH];
  qptr_t  rd_ptr_q, rd_ptr_d;
  qptr_t  wr_ptr_q, wr_ptr_d;
  qptr_t  count_q, count_d;
  logic   pop_ok;

  // Pops on an empty store are dropped so pointers never run ahead of data.
  assign pop_ok = pop_i && (count_q != '0);

  // Next pointers and occupancy; load and pop may land in the same cycle.
  always_comb begin
    rd_ptr_d = pop_ok  ? ptr_add(rd_ptr_q, 4'd1) : rd_ptr_q;
    wr_ptr_d = wr_en_i ? ptr_add(wr_ptr_q, 4'(BAG_SIZE)) : wr_ptr_q;
    count_d  = count_q + (wr_en_i ? 4'(BAG_SIZE) : 4'd0) - {3'b000, pop_ok};
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bag write: slot 0 lands at the tail so it is dealt first.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < int'(BAG_SIZE); k++) begin
        mem_q[ptr_add(wr_ptr_q, 4'(k))] <= wr_data_i[3*k +: 3];
      end
    end
  end

  // Head and preview views; entries beyond the occupancy read as zero.
  always_comb begin
    head_o          = '0;
    head_valid_o    = (count_q != '0);
    preview_o       = '0;
    preview_valid_o = '0;
    if (head_valid_o) head_o = mem_q[rd_ptr_q];
    for (int i = 0; i < int'(PREVIEW_N); i++) begin
      if (int'(count_q) >= i + 2) begin
        preview_valid_o[i]   = 1'b1;
        preview_o[3*i +: 3]  = mem_q[ptr_add(rd_ptr_q, 4'(i + 1))];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/piece_queue.sv
// Piece queue: keeps up to two bags buffered and refills via a 4-phase bag handshake.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int unsigned PREVIEW_N = 3
) (
  input logic           clk,
  input logic           reset,
  piece_queue_if.master bus
);

  req_state_t             state_q, state_d;
  logic                   newbag;
  logic                   load;
  logic                   pop_ok;
  logic                   underflow_q;
  qptr_t                  count;
  qptr_t                  count_after_pop;
  piece_t                 head;
  logic                   head_valid;
  logic [3*PREVIEW_N-1:0] preview;
  logic [PREVIEW_N-1:0]   preview_valid;

  assign pop_ok          = bus.pop && (count != '0);
  assign count_after_pop = count - {3'b000, pop_ok};

  // Request state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Request sequencing; a ready left high (e.g. across reset) routes through release.
  always_comb begin
    state_d = state_q;
    newbag  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_after_pop <= 4'(BAG_SIZE)) state_d = bus.ready ? StRelease : StReq;
      end
      StReq: begin
        newbag = 1'b1;
        if (bus.ready) begin
          load    = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!bus.ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One-cycle flag for a pop attempted on an empty queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= bus.pop && (count == '0);
  end

  piece_fifo #(
    .PREVIEW_N (PREVIEW_N)
  ) u_fifo (
    .clk_i           (clk),
    .rst_i           (reset),
    .wr_en_i         (load),
    .wr_data_i       (bus.pieces),
    .pop_i           (bus.pop),
    .count_o         (count),
    .head_o          (head),
    .head_valid_o    (head_valid),
    .preview_o       (preview),
    .preview_valid_o (preview_valid)
  );

  assign bus.newbag        = newbag;
  assign bus.piece         = head;
  assign bus.piece_valid   = head_valid;
  assign bus.preview       = preview;
  assign bus.preview_valid = preview_valid;
  assign bus.underflow     = underflow_q;

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: queue-based reference model checked every cycle, plus directed
// literal expectations and a randomised bag/pop phase.
module tb_piece_queue;

  localparam int PN = 3;
  localparam int MIdle = 0;
  localparam int MReq  = 1;
  localparam int MRel  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  piece_queue_if #(.PREVIEW_N(PN)) bus ();

  piece_queue #(.PREVIEW_N(PN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the queue contents and the handshake phase.
  logic [2:0] mq[$];
  int         m_phase;
  bit         m_uf;
  bit         m_pop_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    m_phase = MIdle;
    m_uf    = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_phase = MIdle;
        m_uf    = 1'b0;
      end else begin
        m_pop_ok = bus.pop && (mq.size() > 0);
        m_uf     = bus.pop && (mq.size() == 0);
        if (m_pop_ok) void'(mq.pop_front());
        case (m_phase)
          MIdle: if (mq.size() <= 7) m_phase = bus.ready ? MRel : MReq;
          MReq: begin
            if (bus.ready) begin
              for (int k = 0; k < 7; k++) mq.push_back(bus.pieces[3*k +: 3]);
              m_phase = MRel;
            end
          end
          default: if (!bus.ready) m_phase = MIdle;
        endcase
      end
    end
  end

  task automatic compare_all();
    logic [3*PN-1:0] pv;
    logic [PN-1:0]   pvv;
    logic [2:0]      pc;
    pv  = '0;
    pvv = '0;
    pc  = (mq.size() > 0) ? mq[0] : 3'd0;
    for (int i = 0; i < PN; i++) begin
      if (mq.size() > i + 1) begin
        pv[3*i +: 3] = mq[i+1];
        pvv[i]       = 1'b1;
      end
    end
    check("m_newbag", bus.newbag, m_phase == MReq);
    check("m_piece", bus.piece, pc);
    check("m_piece_valid", bus.piece_valid, mq.size() > 0);
    check("m_preview", bus.preview, pv);
    check("m_preview_valid", bus.preview_valid, pvv);
    check("m_underflow", bus.underflow, m_uf);
    check("m_no_rerequest", bus.newbag && bus.ready && (m_phase == MRel), 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_newbag(input int maxc);
    int c;
    c = 0;
    while (!bus.newbag && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("newbag_wait", bus.newbag, 1'b1);
  endtask

  logic [20:0] bag_up, bag_down, bag_b;
  int exp_seq[14] = '{0, 1, 2, 3, 4, 5, 6, 6, 5, 4, 3, 2, 1, 0};
  int exp_b[13]   = '{1, 2, 3, 4, 5, 6, 7, 5, 3, 1, 7, 2, 4};
  int bags, cycles, rdy_hold, dly;

  initial begin
    bag_up   = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    bag_down = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    bag_b    = {3'd4, 3'd2, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};
    bus.ready  = 1'b0;
    bus.pop    = 1'b0;
    bus.pieces = '0;
    reset      = 1'b1;
    cyc(2);
    check("rst_newbag", bus.newbag, 1'b0);
    check("rst_piece_valid", bus.piece_valid, 1'b0);
    check("rst_preview_valid", bus.preview_valid, 3'b000);
    check("rst_piece", bus.piece, 3'd0);
    reset = 1'b0;

    // First request one cycle after reset release, then first bag.
    cyc(1);
    check("first_req", bus.newbag, 1'b1);
    bus.ready  = 1'b1;
    bus.pieces = bag_up;
    cyc(1);
    check("load1_piece", bus.piece, 3'd0);
    check("load1_preview", bus.preview, 9'h0D1);
    check("load1_pvalid", bus.preview_valid, 3'b111);
    check("load1_newbag", bus.newbag, 1'b0);
    bus.ready = 1'b0;
    wait_newbag(2);
    bus.ready  = 1'b1;
    bus.pieces = bag_down;
    cyc(1);
    bus.ready = 1'b0;

    // Drain both bags back-to-back.
    for (int k = 0; k < 14; k++) begin
      check("pop_seq", bus.piece, exp_seq[k]);
      if (k == 6) check("refill_not_yet", bus.newbag, 1'b0);
      if (k == 7) check("refill_at_7", bus.newbag, 1'b1);
      bus.pop = 1'b1;
      cyc(1);
    end
    check("drained_valid", bus.piece_valid, 1'b0);

    // Pop on empty.
    cyc(1);
    check("uf_pulse", bus.underflow, 1'b1);
    check("uf_valid", bus.piece_valid, 1'b0);
    bus.pop = 1'b0;
    cyc(1);
    check("uf_gone", bus.underflow, 1'b0);

    // Pop on the load cycle with count 7.
    bus.ready  = 1'b1;
    bus.pieces = bag_up;
    cyc(1);
    bus.ready = 1'b0;
    wait_newbag(3);
    bus.ready  = 1'b1;
    bus.pieces = bag_b;
    bus.pop    = 1'b1;
    cyc(1);
    bus.ready = 1'b0;
    bus.pop   = 1'b0;
    check("lp_piece", bus.piece, 3'd1);
    check("lp_preview", bus.preview, 9'h11A);
    for (int k = 0; k < 13; k++) begin
      check("lp_seq", bus.piece, exp_b[k]);
      bus.pop = 1'b1;
      cyc(1);
    end
    bus.pop = 1'b0;
    check("lp_drained", bus.piece_valid, 1'b0);

    // Reset mid-request with stale ready held high across release.
    bus.ready  = 1'b1;
    bus.pieces = bag_up;
    cyc(1);
    bus.ready = 1'b0;
    wait_newbag(3);
    check("pre_rst_valid", bus.piece_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_newbag", bus.newbag, 1'b0);
    check("async_valid", bus.piece_valid, 1'b0);
    check("async_pvalid", bus.preview_valid, 3'b000);
    bus.ready = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    check("stale_ready_newbag", bus.newbag, 1'b0);
    check("stale_ready_valid", bus.piece_valid, 1'b0);
    bus.ready = 1'b0;
    wait_newbag(4);
    bus.ready  = 1'b1;
    bus.pieces = bag_down;
    cyc(1);
    bus.ready = 1'b0;
    check("post_rst_piece", bus.piece, 3'd6);

    // Random bags and pop gaps.
    bags     = 0;
    cycles   = 0;
    rdy_hold = 0;
    dly      = $urandom_range(0, 3);
    while (bags < 20 && cycles < 4000) begin
      bus.pop = ($urandom_range(0, 3) != 0);
      if (bus.ready) begin
        if (rdy_hold == 0) bus.ready = 1'b0;
        else rdy_hold--;
      end else if (bus.newbag) begin
        if (dly == 0) begin
          for (int k = 0; k < 7; k++) bus.pieces[3*k +: 3] = 3'($urandom_range(0, 7));
          bus.ready = 1'b1;
          bags++;
          rdy_hold = $urandom_range(0, 2);
          dly      = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
      cyc(1);
      cycles++;
    end
    check("rand_bags", bags, 20);
    cyc(1);
    bus.ready = 1'b0;
    cycles = 0;
    bus.pop = 1'b1;
    while (bus.piece_valid && cycles < 300) begin
      cyc(1);
      cycles++;
    end
    bus.pop = 1'b0;
    check("final_drain", bus.piece_valid, 1'b0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter PREVIEW_N, default 3, number of upcoming pieces exposed after the head (1..6).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port newbag  output  1  bag request to randombag; level, held until ready is seen.
REQ-005 SHALL have port ready  input  1  bag-complete strobe/level from randombag.
REQ-006 SHALL have port pieces  input  21  seven 3-bit piece IDs; slot k at [3k+2:3k], slot 0 dealt first.
REQ-007 SHALL have port pop  input  1  game logic consumes head piece this cycle.
REQ-008 SHALL have port piece  output  3  head piece ID.
REQ-009 SHALL have port piece_valid  output  1  head piece is valid.
REQ-010 SHALL have port preview  output  3*PREVIEW_N  pieces after head, entry i at [3i+2:3i].
REQ-011 SHALL have port preview_valid  output  PREVIEW_N  per-entry valid.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse: pop while piece_valid low.

Function
REQ-013 SHALL hold a FIFO of QUEUE_DEPTH=14 3-bit entries (two bags) with 4-bit count 0..14.
REQ-014 SHALL run request FSM IDLE -> REQ -> RELEASE -> IDLE.
REQ-015 IDLE: newbag=0; go REQ when count minus same-cycle pop is <= 7.
REQ-016 REQ: newbag=1; on cycle ready sampled 1, write all 7 slots (slot 0 first) to tail, go RELEASE.
REQ-017 RELEASE: newbag=0; stay until ready sampled 0, then IDLE (4-phase handshake; no re-request while ready high).
REQ-018 Load and pop in same cycle SHALL both take effect: count_next = count + 7 - 1.
REQ-019 Load SHALL never overflow; REQ entry guarantees count <= 7 at load.
REQ-020 pop with count=0 SHALL be ignored (no pointer/count change) and pulse underflow next cycle.
REQ-021 piece/preview SHALL be registered views of FIFO head; after accepted pop, new head visible the next cycle (latency 1).
REQ-022 piece_valid = (count>=1); preview_valid[i] = (count>=i+2).
REQ-023 Invalid entries SHALL drive 3'b000 on piece/preview.
REQ-024 Pointers SHALL wrap modulo 14; no ordering break across wrap.
REQ-025 Piece value 3'b111 from randombag SHALL be stored unchanged (no filtering).
REQ-026 First request SHALL issue one cycle after reset deassertion (count=0 -> REQ).

Reset
REQ-027 On reset: count=0, pointers=0, FSM=IDLE, newbag=0, piece=0, piece_valid=0, preview=0, preview_valid=0, underflow=0.
REQ-028 Reset asserted mid-REQ SHALL drop newbag immediately (asynchronously) and discard the pending bag.
REQ-029 After reset, a ready still high SHALL not be taken as a load; FSM SHALL pass through REQ only after ready low (enter via RELEASE if ready high).

Structure
REQ-030 tetris_pkg SHALL hold piece_t (3-bit), BAG_SIZE=7, QUEUE_DEPTH=14, state enum req_state_t.
REQ-031 One sub-module piece_fifo (14x3, 7-wide write port, single pop, head+PREVIEW_N read) SHALL hold storage; FSM stays in piece_queue.

Verification
REQ-032 Reset release, randombag model returns bag 0..6 -> newbag high 1 cycle after reset; piece=0, preview=1,2,3, count 7; second request issued immediately, after load count=14.
REQ-033 Pop 14 times back-to-back over two bags {0..6},{6..0} -> pieces 0,1,..,6,6,5,..,0 in order, one per cycle, refill requested when count hits 7.
REQ-034 Pop on the exact cycle ready is sampled with count=7 -> count becomes 13, head advances, no lost piece.
REQ-035 Pop with count=0 -> underflow pulse 1 cycle, piece_valid stays 0, count stays 0.
REQ-036 Assert reset while newbag=1 and ready low -> newbag 0 same cycle, all outputs reset values; ready held high across release -> no load until ready low then high again.
REQ-037 Run 20 bags with random pop gaps -> scoreboard order matches bag order across pointer wrap; newbag never high while ready high in RELEASE.
